io_memory_bank: RTL

Memory-mapped I/O bank on the PicoRV32 native memory bus. It provides NUM_OUT byte-writable 32-bit output registers, each with a one-cycle update strobe, and an inbound 32-bit FIFO with status and sticky overflow. It sits beside RAM on the SoC bus and only responds to its own address window. It is the generalised successor to the single-register output port: multiple channels, readback, an input path, and an interrupt.

---
 rtl/io_memory_bank.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/io_memory_bank.sv
// ---------------------------------------------------------------------------
// io_memory_bank
//   Memory-mapped I/O bank for the PicoRV32 native memory bus. Provides
//   NUM_OUT byte-writable 32-bit output registers, each with a one-cycle
//   update strobe, and an inbound 32-bit FIFO with status, a sticky overflow
//   flag and a not-empty interrupt. Only addresses inside the 256-byte window
//   starting at BASE_ADDR are answered; everything else is left to other
//   slaves on the bus.
//
//   Address map (word offsets inside the window, mem_addr[1:0] ignored):
//     0x00 + 4*i  OUT[i]  (i < NUM_OUT), read/write, byte strobes honoured
//     0x80        FIFO data, read pops the head word (0 when empty)
//     0x84        STATUS: [0] empty, [1] full, [2] overflow, [15:8] count;
//                 writing wdata[2]=1 with wstrb[0]=1 clears overflow
//     other       read 0, write ignored, still acknowledged
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   mem_valid  in   request valid
//   mem_ready  out  one-cycle acknowledge, one cycle after acceptance
//   mem_addr   in   byte address
//   mem_wdata  in   write data
//   mem_wstrb  in   byte strobes, 0 = read
//   mem_rdata  out  read data, valid while mem_ready=1, otherwise 0
//   out_data   out  output registers, channel i at [32*i+31:32*i]
//   out_en     out  per-channel update strobe, coincident with mem_ready
//   in_strobe  in   FIFO push request (no backpressure)
//   in_data    in   FIFO push data
//   irq        out  FIFO not empty (registered)
// ---------------------------------------------------------------------------
module io_memory_bank #(
   parameter int          NUM_OUT   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          IN_DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   output logic [31:0]            mem_rdata,
   output logic [32*NUM_OUT-1:0]  out_data,
   output logic [NUM_OUT-1:0]     out_en,
   input  logic                   in_strobe,
   input  logic [31:0]            in_data,
   output logic                   irq
);

   localparam int          PW       = $clog2(IN_DEPTH);
   localparam int          CW       = PW + 1;
   localparam logic [5:0]  NOUT_W   = 6'(NUM_OUT);
   localparam logic [CW-1:0] DEPTH_C = CW'(IN_DEPTH);

   // Bus response and output channel state
   logic                        r_ready;
   logic [31:0]                 r_rdata;
   logic [NUM_OUT-1:0][31:0]    r_out;
   logic [NUM_OUT-1:0]          r_out_en;

   // Inbound FIFO state
   logic [31:0]                 r_mem [IN_DEPTH];
   logic [PW-1:0]               r_rd_ptr;
   logic [PW-1:0]               r_wr_ptr;
   logic [CW-1:0]               r_count;
   logic                        r_ovf;
   logic                        r_irq;

   logic                        w_in_win;
   logic                        w_accept;
   logic                        w_is_read;
   logic [4:0]                  w_word;
   logic                        w_sel_out;
   logic                        w_sel_fifo;
   logic                        w_sel_stat;
   logic                        w_empty;
   logic                        w_full;
   logic                        w_pop;
   logic                        w_push;
   logic                        w_ovf_set;
   logic                        w_ovf_clr;
   logic [CW-1:0]               w_count_nxt;
   logic [31:0]                 w_status;
   logic [31:0]                 w_out_rd;
   logic [31:0]                 w_rd_val;
   logic                        w_unused_addr;

   // Address decode and handshake
   assign w_in_win   = (mem_addr[31:8] == BASE_ADDR[31:8]);
   // !r_ready keeps a request that is still held during its ack cycle from
   // being accepted a second time.
   assign w_accept   = mem_valid && !r_ready && w_in_win;
   assign w_is_read  = (mem_wstrb == 4'b0000);
   assign w_word     = mem_addr[6:2];
   assign w_sel_out  = !mem_addr[7] && ({1'b0, w_word} < NOUT_W);
   assign w_sel_fifo = (mem_addr[7:2] == 6'h20);
   assign w_sel_stat = (mem_addr[7:2] == 6'h21);
   assign w_unused_addr = &{1'b0, mem_addr[1:0]};

   // FIFO control. A pop in the same cycle frees the slot the push needs, so
   // a full FIFO still accepts the push and no overflow is flagged.
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_pop     = w_accept && w_sel_fifo && w_is_read && !w_empty;
   assign w_push    = in_strobe && (!w_full || w_pop);
   assign w_ovf_set = in_strobe && w_full && !w_pop;
   assign w_ovf_clr = w_accept && w_sel_stat && mem_wstrb[0] && mem_wdata[2];

   assign w_status  = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Read data mux; writes return 0
   always_comb begin
      w_out_rd = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (w_word == 5'(i)) begin
            w_out_rd = r_out[i];
         end
      end
      w_rd_val = '0;
      if (w_is_read) begin
         if (w_sel_out) begin
            w_rd_val = w_out_rd;
         end else if (w_sel_fifo) begin
            w_rd_val = w_empty ? 32'h0 : r_mem[r_rd_ptr];
         end else if (w_sel_stat) begin
            w_rd_val = w_status;
         end
      end
   end

   // Registered response, output channels and FIFO bookkeeping
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready  <= 1'b0;
         r_rdata  <= '0;
         r_out    <= '0;
         r_out_en <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_ready <= w_accept;
         r_rdata <= w_accept ? w_rd_val : 32'h0;

         for (int i = 0; i < NUM_OUT; i++) begin
            r_out_en[i] <= w_accept && w_sel_out && !w_is_read && (w_word == 5'(i));
            for (int b = 0; b < 4; b++) begin
               if (w_accept && w_sel_out && (w_word == 5'(i)) && mem_wstrb[b]) begin
                  r_out[i][8*b +: 8] <= mem_wdata[8*b +: 8];
               end
            end
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_count <= w_count_nxt;

         // Set has priority over a clear arriving in the same cycle
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end

         r_irq <= (w_count_nxt != '0);
      end
   end

   // FIFO storage carries no reset; only words behind valid pointers are read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   assign mem_ready = r_ready;
   assign mem_rdata = r_rdata;
   assign out_data  = r_out;
   assign out_en    = r_out_en;
   assign irq       = r_irq;

endmodule
